// File: rtl/match_score_ctl.sv
// Penalty shoot-out score controller: alternating kicks, configurable regulation length,
// optional early decision and sudden-death pairs with an optional draw limit.
module match_score_ctl #(
   parameter int ROUNDS    = 5,
   parameter int MAX_SD    = 0,
   parameter int EARLY_END = 1,
   parameter int SCORE_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               match_active,
   input  logic               first_shooter,
   input  logic               round_done,
   input  logic               is_scored,
   output logic [SCORE_W-1:0] score_player,
   output logic [SCORE_W-1:0] score_enemy,
   output logic               shooter,
   output logic               sudden_death,
   output logic               match_end,
   output logic               match_over,
   output logic               match_result,
   output logic               match_draw
);

   localparam int KW  = $clog2(2 * ROUNDS + 1);
   localparam int SDW = (MAX_SD > 0) ? $clog2(MAX_SD + 1) : 1;
   localparam int AW  = ((SCORE_W > KW) ? SCORE_W : KW) + 2;

   localparam logic [SCORE_W-1:0] SMAX  = '1;
   localparam logic [KW-1:0]      KMAX  = '1;
   localparam logic [SDW-1:0]     SDMAX = '1;

   typedef enum logic [1:0] {IDLE, REG, SD, FIN} state_e;

   state_e             state_q;
   logic [SCORE_W-1:0] sp_q, se_q, sp_d, se_d;
   logic [KW-1:0]      kp_q, ke_q, kp_d, ke_d;
   logic [SDW-1:0]     sdp_q, sdp_d;
   logic               shooter_q, first_q, sd_q, end_q, over_q, result_q, draw_q;

   logic [AW-1:0] spx, sex, kpx, kex;
   logic          player_ahead, enemy_ahead, reg_done, pair_done;
   logic          win_p, win_e, draw_now, to_sd;

   // Post-kick values: every decision below is taken on these, not on the registers.
   always_comb begin
      sp_d = sp_q;
      se_d = se_q;
      kp_d = kp_q;
      ke_d = ke_q;
      if (!shooter_q) begin
         if (kp_q != KMAX) kp_d = kp_q + KW'(1);
         if (is_scored && sp_q != SMAX) sp_d = sp_q + SCORE_W'(1);
      end else begin
         if (ke_q != KMAX) ke_d = ke_q + KW'(1);
         if (is_scored && se_q != SMAX) se_d = se_q + SCORE_W'(1);
      end
      sdp_d = (sdp_q != SDMAX) ? sdp_q + SDW'(1) : sdp_q;
   end

   always_comb begin
      spx          = AW'(sp_d);
      sex          = AW'(se_d);
      kpx          = AW'(kp_d);
      kex          = AW'(ke_d);
      player_ahead = sp_d > se_d;
      enemy_ahead  = se_d > sp_d;
      reg_done     = (kpx + kex) == AW'(2 * ROUNDS);
      pair_done    = shooter_q != first_q;
      win_p        = 1'b0;
      win_e        = 1'b0;
      draw_now     = 1'b0;
      to_sd        = 1'b0;
      if (state_q == REG) begin
         // Remaining kicks of the trailing side bound how far it can still catch up.
         if (EARLY_END != 0 && spx > sex + AW'(ROUNDS) - kex) begin
            win_p = 1'b1;
         end else if (EARLY_END != 0 && sex > spx + AW'(ROUNDS) - kpx) begin
            win_e = 1'b1;
         end else if (reg_done) begin
            win_p = player_ahead;
            win_e = enemy_ahead;
            to_sd = !player_ahead && !enemy_ahead;
         end
      end else if (state_q == SD && pair_done) begin
         win_p    = player_ahead;
         win_e    = enemy_ahead;
         draw_now = !player_ahead && !enemy_ahead && MAX_SD != 0 && int'(sdp_q) + 1 == MAX_SD;
      end
   end

   // NOTE: all state is registered with non-blocking assignments in this single block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sp_q      <= '0;
         se_q      <= '0;
         kp_q      <= '0;
         ke_q      <= '0;
         sdp_q     <= '0;
         shooter_q <= 1'b0;
         first_q   <= 1'b0;
         sd_q      <= 1'b0;
         end_q     <= 1'b0;
         over_q    <= 1'b0;
         result_q  <= 1'b0;
         draw_q    <= 1'b0;
      end else begin
         end_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (match_active) begin
                  sp_q      <= '0;
                  se_q      <= '0;
                  kp_q      <= '0;
                  ke_q      <= '0;
                  sdp_q     <= '0;
                  over_q    <= 1'b0;
                  result_q  <= 1'b0;
                  draw_q    <= 1'b0;
                  sd_q      <= 1'b0;
                  shooter_q <= first_shooter;
                  first_q   <= first_shooter;
                  state_q   <= REG;
               end
            end
            REG, SD: begin
               if (!match_active) begin
                  state_q <= IDLE;
                  sd_q    <= 1'b0;
               end else if (round_done) begin
                  sp_q <= sp_d;
                  se_q <= se_d;
                  kp_q <= kp_d;
                  ke_q <= ke_d;
                  if (state_q == SD && pair_done) sdp_q <= sdp_d;
                  if (win_p || win_e || draw_now) begin
                     state_q  <= FIN;
                     end_q    <= 1'b1;
                     over_q   <= 1'b1;
                     result_q <= win_p;
                     draw_q   <= draw_now;
                     sd_q     <= 1'b0;
                  end else begin
                     shooter_q <= ~shooter_q;
                     if (to_sd) begin
                        state_q <= SD;
                        sd_q    <= 1'b1;
                     end
                  end
               end
            end
            FIN: begin
               if (!match_active) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign score_player = sp_q;
   assign score_enemy  = se_q;
   assign shooter      = shooter_q;
   assign sudden_death = sd_q;
   assign match_end    = end_q;
   assign match_over   = over_q;
   assign match_result = result_q;
   assign match_draw   = draw_q;

endmodule

// File: tb/tb_match_score_ctl.sv
// Bench for match_score_ctl: four parameter sets driven in parallel, directed scenarios then
// random traffic, all outputs compared every cycle against an integer-level match model.
module tb_match_score_ctl;

   logic clk = 1'b0;
   logic rst, match_active, first_shooter, round_done, is_scored;
   always #5 clk = ~clk;

   logic [3:0] sp_o [3];
   logic [3:0] se_o [3];
   logic [1:0] sp_s, se_s;
   logic [3:0] shooter_o, sd_o, end_o, over_o, res_o, draw_o;

   // u0: default; u1: no early end; u2: two sudden-death pairs max; u3: 2-bit saturating scores.
   match_score_ctl #(.ROUNDS(5), .MAX_SD(0), .EARLY_END(1), .SCORE_W(4)) u0 (
      .clk(clk), .rst(rst), .match_active(match_active), .first_shooter(first_shooter),
      .round_done(round_done), .is_scored(is_scored), .score_player(sp_o[0]), .score_enemy(se_o[0]),
      .shooter(shooter_o[0]), .sudden_death(sd_o[0]), .match_end(end_o[0]), .match_over(over_o[0]),
      .match_result(res_o[0]), .match_draw(draw_o[0]));
   match_score_ctl #(.ROUNDS(5), .MAX_SD(0), .EARLY_END(0), .SCORE_W(4)) u1 (
      .clk(clk), .rst(rst), .match_active(match_active), .first_shooter(first_shooter),
      .round_done(round_done), .is_scored(is_scored), .score_player(sp_o[1]), .score_enemy(se_o[1]),
      .shooter(shooter_o[1]), .sudden_death(sd_o[1]), .match_end(end_o[1]), .match_over(over_o[1]),
      .match_result(res_o[1]), .match_draw(draw_o[1]));
   match_score_ctl #(.ROUNDS(5), .MAX_SD(2), .EARLY_END(1), .SCORE_W(4)) u2 (
      .clk(clk), .rst(rst), .match_active(match_active), .first_shooter(first_shooter),
      .round_done(round_done), .is_scored(is_scored), .score_player(sp_o[2]), .score_enemy(se_o[2]),
      .shooter(shooter_o[2]), .sudden_death(sd_o[2]), .match_end(end_o[2]), .match_over(over_o[2]),
      .match_result(res_o[2]), .match_draw(draw_o[2]));
   match_score_ctl #(.ROUNDS(5), .MAX_SD(0), .EARLY_END(0), .SCORE_W(2)) u3 (
      .clk(clk), .rst(rst), .match_active(match_active), .first_shooter(first_shooter),
      .round_done(round_done), .is_scored(is_scored), .score_player(sp_s), .score_enemy(se_s),
      .shooter(shooter_o[3]), .sudden_death(sd_o[3]), .match_end(end_o[3]), .match_over(over_o[3]),
      .match_result(res_o[3]), .match_draw(draw_o[3]));

   int c_rounds [4] = '{5, 5, 5, 5};
   int c_maxsd  [4] = '{0, 0, 2, 0};
   int c_early  [4] = '{1, 0, 1, 0};
   int c_smax   [4] = '{15, 15, 15, 3};

   // phase: 0 idle, 1 regulation, 2 sudden death, 3 finished
   typedef struct {
      int phase, sp, se, kp, ke, sdp;
      int shooter, first, sd, endp, over, result, draw;
   } mdl_t;
   mdl_t m [4];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic mdl_t step(mdl_t cur, int i, bit r, bit act, bit fs, bit rd, bit sc);
      mdl_t n;
      int   winner;   // 0 none, 1 player, 2 enemy, 3 draw
      bit   go_sd;
      n      = cur;
      n.endp = 0;
      winner = 0;
      go_sd  = 1'b0;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      if (cur.phase == 0) begin
         if (act) begin
            n = '{default: 0};
            n.phase = 1; n.shooter = fs; n.first = fs;
         end
      end else if (!act) begin
         n.phase = 0;
         n.sd    = 0;
      end else if ((cur.phase == 1 || cur.phase == 2) && rd) begin
         if (cur.shooter == 0) begin
            n.kp++;
            if (sc) n.sp = (cur.sp + 1 > c_smax[i]) ? c_smax[i] : cur.sp + 1;
         end else begin
            n.ke++;
            if (sc) n.se = (cur.se + 1 > c_smax[i]) ? c_smax[i] : cur.se + 1;
         end
         if (cur.phase == 1) begin
            if (c_early[i] != 0 && n.sp > n.se + c_rounds[i] - n.ke) winner = 1;
            else if (c_early[i] != 0 && n.se > n.sp + c_rounds[i] - n.kp) winner = 2;
            else if (n.kp + n.ke == 2 * c_rounds[i]) begin
               if (n.sp > n.se) winner = 1;
               else if (n.se > n.sp) winner = 2;
               else go_sd = 1'b1;
            end
         end else if (cur.shooter != cur.first) begin
            n.sdp++;
            if (n.sp > n.se) winner = 1;
            else if (n.se > n.sp) winner = 2;
            else if (c_maxsd[i] != 0 && n.sdp == c_maxsd[i]) winner = 3;
         end
         if (winner != 0) begin
            n.phase = 3; n.endp = 1; n.over = 1; n.sd = 0;
            n.result = (winner == 1); n.draw = (winner == 3);
         end else begin
            n.shooter = 1 - cur.shooter;
            if (go_sd) begin
               n.phase = 2; n.sd = 1;
            end
         end
      end
      return n;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] osp, ose;
      for (int i = 0; i < 4; i++) begin
         osp = (i < 3) ? 32'(sp_o[i]) : 32'(sp_s);
         ose = (i < 3) ? 32'(se_o[i]) : 32'(se_s);
         check($sformatf("u%0d.score_player", i), osp, m[i].sp);
         check($sformatf("u%0d.score_enemy", i), ose, m[i].se);
         check($sformatf("u%0d.shooter", i), 32'(shooter_o[i]), m[i].shooter);
         check($sformatf("u%0d.sudden_death", i), 32'(sd_o[i]), m[i].sd);
         check($sformatf("u%0d.match_end", i), 32'(end_o[i]), m[i].endp);
         check($sformatf("u%0d.match_over", i), 32'(over_o[i]), m[i].over);
         check($sformatf("u%0d.match_result", i), 32'(res_o[i]), m[i].result);
         check($sformatf("u%0d.match_draw", i), 32'(draw_o[i]), m[i].draw);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 4; i++)
         m[i] = step(m[i], i, rst, match_active, first_shooter, round_done, is_scored);
      #1;
      check_all();
   endtask

   task automatic kick(bit sc);
      round_done = 1'b1;
      is_scored  = sc;
      cycle();
      round_done = 1'b0;
      is_scored  = 1'b0;
   endtask

   int pat3 [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   int pat4 [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

   initial begin
      for (int i = 0; i < 4; i++) m[i] = '{default: 0};
      rst = 1'b1; match_active = 1'b0; first_shooter = 1'b0; round_done = 1'b0; is_scored = 1'b0;
      cycle();
      cycle();
      check("reset.score_player", 32'(sp_o[0]), 0);
      check("reset.match_over", 32'(over_o[0]), 0);
      rst = 1'b0;
      cycle();

      // Early win on the sixth kick; player scores, enemy misses.
      match_active = 1'b1;
      cycle();
      check("start.shooter", 32'(shooter_o[0]), 0);
      for (int k = 1; k <= 5; k++) kick(k[0]);
      check("early.no_end_k5", 32'(end_o[0]), 0);
      check("early.sp_k5", 32'(sp_o[0]), 3);
      kick(1'b0);
      check("early.end_k6", 32'(end_o[0]), 1);
      check("early.se_k6", 32'(se_o[0]), 0);
      check("early.result_k6", 32'(res_o[0]), 1);
      check("noearly.no_end_k6", 32'(end_o[1]), 0);
      cycle();
      check("early.end_one_cycle", 32'(end_o[0]), 0);
      for (int k = 7; k <= 10; k++) begin
         check("noearly.shooter_alt", 32'(shooter_o[1]), 32'((k - 1) % 2));
         kick(k[0]);
      end
      check("noearly.end_k10", 32'(end_o[1]), 1);
      check("noearly.sp_k10", 32'(sp_o[1]), 5);
      check("sat.sp_k10", 32'(sp_s), 3);
      check("fin.ignores_kicks", 32'(sp_o[0]), 3);
      match_active = 1'b0;
      cycle();
      check("abort.over_holds", 32'(over_o[0]), 1);

      // Regulation 3-3, decided in the first sudden-death pair.
      match_active = 1'b1;
      cycle();
      foreach (pat3[k]) kick(pat3[k][0]);
      check("reg33.sudden_death", 32'(sd_o[0]), 1);
      check("reg33.se", 32'(se_o[0]), 3);
      kick(1'b1);
      check("sd.midpair_no_end", 32'(end_o[0]), 0);
      kick(1'b0);
      check("sd.end", 32'(end_o[0]), 1);
      check("sd.result", 32'(res_o[0]), 1);
      check("sd.cleared", 32'(sd_o[0]), 0);
      match_active = 1'b0;
      cycle();

      // 2-2 after regulation, both sides score in two sudden-death pairs.
      match_active = 1'b1;
      cycle();
      foreach (pat4[k]) kick(pat4[k][0]);
      repeat (4) kick(1'b1);
      check("draw.flag", 32'(draw_o[2]), 1);
      check("draw.result", 32'(res_o[2]), 0);
      check("draw.sp", 32'(sp_o[2]), 4);
      check("unlimited.still_sd", 32'(sd_o[0]), 1);

      // Abort coincident with a kick, kicks in IDLE, restart clears.
      match_active = 1'b0;
      cycle();
      match_active = 1'b1;
      cycle();
      kick(1'b1);
      kick(1'b0);
      match_active = 1'b0;
      kick(1'b1);
      check("abort.sp_kept", 32'(sp_o[0]), 1);
      check("abort.no_end", 32'(end_o[0]), 0);
      kick(1'b1);
      check("idle.ignores_kick", 32'(se_o[0]), 0);
      match_active = 1'b1;
      cycle();
      check("restart.sp_cleared", 32'(sp_o[0]), 0);

      // Reset mid-regulation at 2-1.
      kick(1'b1);
      kick(1'b1);
      kick(1'b1);
      check("rst.pre_sp", 32'(sp_o[0]), 2);
      rst = 1'b1;
      cycle();
      check("rst.sp", 32'(sp_o[0]), 0);
      check("rst.shooter", 32'(shooter_o[0]), 0);
      first_shooter = 1'b1;
      rst = 1'b0;
      cycle();
      check("rst.restart_shooter", 32'(shooter_o[0]), 1);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         rst           = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 79) == 0) match_active = !match_active;
         first_shooter = 1'($urandom_range(0, 1));
         round_done    = ($urandom_range(0, 2) == 0);
         is_scored     = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/match_score_ctl.md
Name: match_score_ctl

Overview:
- Parametrised successor to the fixed-length score control.
- Counts penalty kicks for both sides with alternating shooters and a configurable regulation length.
- Optionally ends the match early once the result is mathematically decided, then resolves a regulation tie with sudden-death pairs.
- Sits between gloves/ball control (round_done, is_scored) and the game-state selector and score drawing (match_end, match_result, scores).

Parameters:
- ROUNDS, 5, regulation kicks per side (>=1).
- MAX_SD, 0, maximum sudden-death pairs; 0 = unlimited.
- EARLY_END, 1, 1 = end the match as soon as the result is decided; 0 = always play all regulation kicks.
- SCORE_W, 4, score/counter width; scores saturate at 2^SCORE_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- match_active  in  1  high while a match is in play (derived from game_state)
- first_shooter  in  1  0 = player kicks first, 1 = enemy; sampled at match start
- round_done  in  1  one-cycle pulse, kick finished
- is_scored  in  1  kick result, valid with round_done
- score_player  out  SCORE_W  player goals
- score_enemy  out  SCORE_W  enemy goals
- shooter  out  1  side taking the next kick (0 player, 1 enemy)
- sudden_death  out  1  high in sudden-death phase
- match_end  out  1  one-cycle pulse on match decision
- match_over  out  1  level, high from decision until next match start
- match_result  out  1  1 = player won; valid while match_over
- match_draw  out  1  1 = drawn (MAX_SD exhausted); valid while match_over

Behaviour:
- Reset: state IDLE; all outputs 0; kick counters kp, ke and SD pair count sdp = 0.
- One clock, synchronous active-high reset; it aborts any match in progress.
- States: IDLE, REG, SD, FIN.
- IDLE & match_active=1:
  - clear scores, kp, ke, sdp, match_over, match_result, match_draw;
  - shooter <= first_shooter; latch first_shooter internally; go to REG.
- REG/SD/FIN & match_active=0 -> IDLE.
  - Scores, match_over and result hold, so the end screen can display them.
  - Abort has priority over a simultaneous round_done; that kick is discarded.
- round_done is ignored in IDLE and FIN.
- Kick handling in REG/SD, on round_done:
  - increment the shooter's kick counter;
  - add is_scored to the shooter's score, saturating;
  - toggle shooter.
  - All outputs update on the next edge (latency 1 cycle).
- Decisions are evaluated on the post-kick (next) values in the same cycle.
- REG, EARLY_END=1, after every kick:
  - player wins if sp > se + (ROUNDS - ke);
  - enemy wins if se > sp + (ROUNDS - kp).
- REG, after kick 2*ROUNDS:
  - if sp != se, the higher score wins;
  - if tied, go to SD and assert sudden_death.
- SD:
  - a pair is complete when the kick just taken was by the non-first side;
  - on pair completion: sdp+1; if sp != se, the higher score wins;
  - else if MAX_SD != 0 and sdp+1 == MAX_SD -> draw;
  - a mid-pair score difference never ends the match.
- Win/draw:
  - go to FIN; match_end=1 for exactly one cycle; match_over=1;
  - set match_result/match_draw; sudden_death=0; shooter holds.
- Counter widths are sized for 2*ROUNDS and MAX_SD.
- Unlimited SD is non-terminating only if ties persist; scores saturate and the comparison uses saturated values.
- match_end is never asserted twice per match.

Test Plan:
- Early win, decided on 6th kick: ROUNDS=5, EARLY_END=1, first_shooter=0; player scores every kick, enemy misses every kick.
  -> no match_end after kick 5 (3-0, enemy has 3 left).
  -> match_end pulse 1 cycle after the 6th round_done; score 3-0, match_result=1, match_over=1.
- Same stimulus, EARLY_END=0.
  -> end only after the 10th kick; 5-0, result 1; shooter alternates 0,1,0,... throughout.
- Regulation ends 3-3.
  -> sudden_death=1 after kick 10.
  -> kick 11: player scores (4-3), no end.
  -> kick 12: enemy misses -> match_end, result 1, sudden_death=0.
- MAX_SD=2, tied 2-2 after regulation; both score in both SD pairs.
  -> after kick 14: match_draw=1, match_result=0, score 4-4.
- Abort and ignored kicks:
  -> round_done coincident with match_active falling: scores unchanged, state IDLE, no match_end.
  -> round_done pulses in IDLE and FIN: no change.
  -> re-raising match_active clears scores.
- rst asserted mid-REG at 2-1: all outputs 0 on the next cycle.
  -> a subsequent match starts cleanly with shooter = first_shooter.
